ddr3_frame_scheduler: RTL and testbench



---
 rtl/ddr3_sched_pkg.sv | 12 +
 rtl/frame_bank_ctrl.sv | 49 ++++
 rtl/ddr3_frame_scheduler.sv | 233 +++++++++++++++++++++++
 tb/tb_ddr3_frame_scheduler.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_sched_pkg.sv
// Shared types for the DDR3 frame scheduler: FSM encodings, bank count and bank base address.
package ddr3_sched_pkg;
   typedef enum logic [1:0] {W_IDLE, W_START, W_BUSY} wr_state_t;
   typedef enum logic [1:0] {R_IDLE, R_START, R_BUSY} rd_state_t;

   typedef logic [1:0] bank_t;
   localparam bank_t NUM_BANKS = 2'd3;

   function automatic logic [31:0] bank_base(input bank_t bank, input logic [31:0] stride);
      return 32'(bank) * stride;
   endfunction
endpackage

// File: rtl/frame_bank_ctrl.sv
// Triple-buffer bank bookkeeping: write, read and last-completed bank with next-bank selection.
module frame_bank_ctrl
   import ddr3_sched_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_switch,
   input  logic       rd_switch,
   input  logic       frame_done,
   output logic [1:0] wr_bank,
   output logic [1:0] rd_bank,
   output logic [1:0] done_bank
);
   bank_t wr_bank_q, wr_bank_d;
   bank_t rd_bank_q, rd_bank_d;
   bank_t done_bank_q, done_bank_d;

   function automatic bank_t bank_inc(input bank_t b);
      return (b == NUM_BANKS - 2'd1) ? 2'd0 : b + 2'd1;
   endfunction

   always_comb begin
      // Read side resolves first so a simultaneous write switch avoids the new display bank.
      rd_bank_d   = rd_switch ? done_bank_q : rd_bank_q;
      done_bank_d = frame_done ? wr_bank_q : done_bank_q;
      wr_bank_d   = wr_bank_q;
      if (wr_switch) begin
         wr_bank_d = bank_inc(wr_bank_q);
         if (wr_bank_d == rd_bank_d)
            wr_bank_d = bank_inc(wr_bank_d);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_bank_q   <= 2'd0;
         rd_bank_q   <= 2'd2;
         done_bank_q <= 2'd2;
      end else begin
         wr_bank_q   <= wr_bank_d;
         rd_bank_q   <= rd_bank_d;
         done_bank_q <= done_bank_d;
      end
   end

   assign wr_bank   = wr_bank_q;
   assign rd_bank   = rd_bank_q;
   assign done_bank = done_bank_q;
endmodule

// File: rtl/ddr3_frame_scheduler.sv
// Triple-buffered video frame scheduler issuing per-line DDR3 write and read bursts.
// Optional FRAME_SCHED_STATS_EN adds drop_cnt / frame_cnt statistics outputs.
module ddr3_frame_scheduler
   import ddr3_sched_pkg::*;
#(
   parameter int                   ADDR_BITS       = 25,
   parameter logic [ADDR_BITS-1:0] LINE_LEN        = 25'd1024,
   parameter int                   LINES_PER_FRAME = 480,
   parameter logic [ADDR_BITS-1:0] FRAME_STRIDE    = 25'h10_0000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_frame_sync,
   input  logic                 line_ready,
   output logic                 wr_start,
   output logic [ADDR_BITS-1:0] wr_addr,
   output logic [ADDR_BITS-1:0] wr_len,
   input  logic                 wr_finish,
   input  logic                 rd_frame_sync,
   input  logic                 rd_line_req,
   output logic                 rd_start,
   output logic [ADDR_BITS-1:0] rd_addr,
   output logic [ADDR_BITS-1:0] rd_len,
   input  logic                 rd_finish,
   output logic [ADDR_BITS-1:0] last_wr_addr,
   output logic [ADDR_BITS-1:0] last_rd_addr,
`ifdef FRAME_SCHED_STATS_EN
   output logic [15:0]          drop_cnt,
   output logic [15:0]          frame_cnt,
`endif
   output logic                 frame_valid
);
   localparam logic [ADDR_BITS-1:0] LPF = ADDR_BITS'(LINES_PER_FRAME);

   wr_state_t wr_state_q, wr_state_d;
   rd_state_t rd_state_q, rd_state_d;
   logic [ADDR_BITS-1:0] wr_line_q, wr_line_d, rd_line_q, rd_line_d;
   logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d, wr_len_q, wr_len_d;
   logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d, rd_len_q, rd_len_d;
   logic [ADDR_BITS-1:0] last_wr_addr_q, last_wr_addr_d, last_rd_addr_q, last_rd_addr_d;
   logic wr_start_q, wr_start_d, rd_start_q, rd_start_d;
   logic wr_pend_q, wr_pend_d, rd_pend_q, rd_pend_d;
   logic frame_valid_q, frame_valid_d;
   logic wr_switch, rd_switch, frame_done;
   logic [1:0] wr_bank, rd_bank, done_bank;
   logic [ADDR_BITS-1:0] wr_base, rd_base, done_base, rd_cur_base, rd_cur_line;

   frame_bank_ctrl u_bank (
      .clk        (clk),
      .rst        (rst),
      .wr_switch  (wr_switch),
      .rd_switch  (rd_switch),
      .frame_done (frame_done),
      .wr_bank    (wr_bank),
      .rd_bank    (rd_bank),
      .done_bank  (done_bank)
   );

   assign wr_base   = ADDR_BITS'(bank_base(wr_bank, 32'(FRAME_STRIDE)));
   assign rd_base   = ADDR_BITS'(bank_base(rd_bank, 32'(FRAME_STRIDE)));
   assign done_base = ADDR_BITS'(bank_base(done_bank, 32'(FRAME_STRIDE)));

   always_comb begin
      wr_state_d     = wr_state_q;
      wr_line_d      = wr_line_q;
      wr_pend_d      = wr_pend_q;
      wr_start_d     = 1'b0;
      wr_addr_d      = wr_addr_q;
      wr_len_d       = wr_len_q;
      frame_valid_d  = frame_valid_q;
      last_wr_addr_d = last_wr_addr_q;
      wr_switch      = 1'b0;
      frame_done     = 1'b0;
      case (wr_state_q)
         W_IDLE: begin
            if (wr_frame_sync) begin
               wr_switch = 1'b1;
               wr_line_d = '0;
            end else if (line_ready && (wr_line_q < LPF) && !wr_pend_q) begin
               wr_state_d = W_START;
               wr_start_d = 1'b1;
               wr_addr_d  = wr_base + wr_line_q * LINE_LEN;
               wr_len_d   = LINE_LEN;
            end
         end
         W_START: begin
            wr_state_d = W_BUSY;
            if (wr_frame_sync) wr_pend_d = 1'b1;
         end
         W_BUSY: begin
            if (wr_finish) begin
               wr_state_d = W_IDLE;
               if (wr_pend_q || wr_frame_sync) begin
                  // Interrupted frame is abandoned, never published as complete.
                  wr_switch = 1'b1;
                  wr_line_d = '0;
                  wr_pend_d = 1'b0;
               end else begin
                  wr_line_d = wr_line_q + 1'b1;
                  if (wr_line_d == LPF) begin
                     frame_done     = 1'b1;
                     frame_valid_d  = 1'b1;
                     last_wr_addr_d = wr_base;
                  end
               end
            end else if (wr_frame_sync) begin
               wr_pend_d = 1'b1;
            end
         end
         default: wr_state_d = W_IDLE;
      endcase
   end

   // A sync in the same cycle as a line request makes that request read line 0 of the new bank.
   assign rd_cur_base = (rd_frame_sync && frame_valid_q) ? done_base : rd_base;
   assign rd_cur_line = rd_frame_sync ? '0 : rd_line_q;

   always_comb begin
      rd_state_d     = rd_state_q;
      rd_line_d      = rd_line_q;
      rd_pend_d      = rd_pend_q;
      rd_start_d     = 1'b0;
      rd_addr_d      = rd_addr_q;
      rd_len_d       = rd_len_q;
      last_rd_addr_d = last_rd_addr_q;
      rd_switch      = 1'b0;
      case (rd_state_q)
         R_IDLE: begin
            if (rd_frame_sync) begin
               rd_line_d = '0;
               rd_switch = frame_valid_q;
            end
            if (rd_line_req && frame_valid_q) begin
               rd_state_d = R_START;
               rd_start_d = 1'b1;
               rd_addr_d  = rd_cur_base + rd_cur_line * LINE_LEN;
               rd_len_d   = LINE_LEN;
            end
         end
         R_START: begin
            rd_state_d = R_BUSY;
            if (rd_frame_sync) rd_pend_d = 1'b1;
         end
         R_BUSY: begin
            if (rd_finish) begin
               rd_state_d = R_IDLE;
               if (rd_pend_q || rd_frame_sync) begin
                  rd_line_d = '0;
                  rd_switch = frame_valid_q;
                  rd_pend_d = 1'b0;
               end else begin
                  rd_line_d = (rd_line_q == LPF - 1'b1) ? '0 : rd_line_q + 1'b1;
               end
            end else if (rd_frame_sync) begin
               rd_pend_d = 1'b1;
            end
         end
         default: rd_state_d = R_IDLE;
      endcase
      if (rd_switch) last_rd_addr_d = done_base;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_state_q     <= W_IDLE;
         rd_state_q     <= R_IDLE;
         wr_line_q      <= '0;
         rd_line_q      <= '0;
         wr_pend_q      <= 1'b0;
         rd_pend_q      <= 1'b0;
         wr_start_q     <= 1'b0;
         rd_start_q     <= 1'b0;
         wr_addr_q      <= '0;
         wr_len_q       <= '0;
         rd_addr_q      <= '0;
         rd_len_q       <= '0;
         last_wr_addr_q <= '0;
         last_rd_addr_q <= '0;
         frame_valid_q  <= 1'b0;
      end else begin
         wr_state_q     <= wr_state_d;
         rd_state_q     <= rd_state_d;
         wr_line_q      <= wr_line_d;
         rd_line_q      <= rd_line_d;
         wr_pend_q      <= wr_pend_d;
         rd_pend_q      <= rd_pend_d;
         wr_start_q     <= wr_start_d;
         rd_start_q     <= rd_start_d;
         wr_addr_q      <= wr_addr_d;
         wr_len_q       <= wr_len_d;
         rd_addr_q      <= rd_addr_d;
         rd_len_q       <= rd_len_d;
         last_wr_addr_q <= last_wr_addr_d;
         last_rd_addr_q <= last_rd_addr_d;
         frame_valid_q  <= frame_valid_d;
      end
   end

`ifdef FRAME_SCHED_STATS_EN
   logic [15:0] drop_cnt_q, drop_cnt_d, frame_cnt_q, frame_cnt_d;
   logic        rd_drop;

   assign rd_drop = rd_line_req && !((rd_state_q == R_IDLE) && frame_valid_q);

   always_comb begin
      drop_cnt_d  = (rd_drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
      frame_cnt_d = frame_done ? frame_cnt_q + 16'd1 : frame_cnt_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         drop_cnt_q  <= 16'd0;
         frame_cnt_q <= 16'd0;
      end else begin
         drop_cnt_q  <= drop_cnt_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign drop_cnt  = drop_cnt_q;
   assign frame_cnt = frame_cnt_q;
`endif

   assign wr_start     = wr_start_q;
   assign wr_addr      = wr_addr_q;
   assign wr_len       = wr_len_q;
   assign rd_start     = rd_start_q;
   assign rd_addr      = rd_addr_q;
   assign rd_len       = rd_len_q;
   assign last_wr_addr = last_wr_addr_q;
   assign last_rd_addr = last_rd_addr_q;
   assign frame_valid  = frame_valid_q;
endmodule

// File: tb/tb_ddr3_frame_scheduler.sv
// Directed bench for ddr3_frame_scheduler with a 4-line frame.
module tb_ddr3_frame_scheduler;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_frame_sync = 1'b0, line_ready = 1'b0, wr_finish = 1'b0;
   logic        rd_frame_sync = 1'b0, rd_line_req = 1'b0, rd_finish = 1'b0;
   logic        wr_start, rd_start, frame_valid;
   logic [24:0] wr_addr, wr_len, rd_addr, rd_len, last_wr_addr, last_rd_addr;
`ifdef FRAME_SCHED_STATS_EN
   logic [15:0] drop_cnt, frame_cnt;
`endif
   int total = 0;
   int bad   = 0;

   ddr3_frame_scheduler #(
      .ADDR_BITS(25), .LINE_LEN(25'd1024), .LINES_PER_FRAME(4), .FRAME_STRIDE(25'h10_0000)
   ) dut (
      .clk(clk), .rst(rst),
      .wr_frame_sync(wr_frame_sync), .line_ready(line_ready),
      .wr_start(wr_start), .wr_addr(wr_addr), .wr_len(wr_len), .wr_finish(wr_finish),
      .rd_frame_sync(rd_frame_sync), .rd_line_req(rd_line_req),
      .rd_start(rd_start), .rd_addr(rd_addr), .rd_len(rd_len), .rd_finish(rd_finish),
      .last_wr_addr(last_wr_addr), .last_rd_addr(last_rd_addr),
`ifdef FRAME_SCHED_STATS_EN
      .drop_cnt(drop_cnt), .frame_cnt(frame_cnt),
`endif
      .frame_valid(frame_valid)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_wr_sync();
      wr_frame_sync = 1'b1;
      tick();
      wr_frame_sync = 1'b0;
   endtask

   // Waits for a write request, checks it, then completes the burst.
   task automatic do_write(input logic [24:0] exp_addr, input string name);
      int n = 0;
      while (wr_start !== 1'b1 && n < 20) begin tick(); n++; end
      total++;
      if (wr_start !== 1'b1 || wr_addr !== exp_addr || wr_len !== 25'd1024) begin
         bad++;
         $display("FAIL %s: start=%b addr=%h len=%h, want start=1 addr=%h len=400", name, wr_start, wr_addr, wr_len, exp_addr);
      end
      tick();
      total++;
      if (wr_start !== 1'b0 || wr_addr !== exp_addr) begin
         bad++;
         $display("FAIL %s_hold: start=%b addr=%h, want start=0 addr=%h", name, wr_start, wr_addr, exp_addr);
      end
      wr_finish = 1'b1;
      tick();
      wr_finish = 1'b0;
   endtask

   task automatic do_read(input logic [24:0] exp_addr, input string name);
      int n = 0;
      rd_line_req = 1'b1;
      tick();
      rd_line_req = 1'b0;
      while (rd_start !== 1'b1 && n < 20) begin tick(); n++; end
      total++;
      if (rd_start !== 1'b1 || rd_addr !== exp_addr || rd_len !== 25'd1024) begin
         bad++;
         $display("FAIL %s: start=%b addr=%h len=%h, want start=1 addr=%h len=400", name, rd_start, rd_addr, rd_len, exp_addr);
      end
      tick();
      rd_finish = 1'b1;
      tick();
      rd_finish = 1'b0;
      tick();
   endtask

   task automatic check_idle_outputs(input string name);
      total++;
      if (wr_start !== 1'b0 || rd_start !== 1'b0 || wr_addr !== 25'h0 || wr_len !== 25'h0 ||
          rd_addr !== 25'h0 || rd_len !== 25'h0 || last_wr_addr !== 25'h0 ||
          last_rd_addr !== 25'h0 || frame_valid !== 1'b0) begin
         bad++;
         $display("FAIL %s: ws=%b rs=%b wa=%h wl=%h ra=%h rl=%h lw=%h lr=%h fv=%b, want all 0",
                  name, wr_start, rd_start, wr_addr, wr_len, rd_addr, rd_len, last_wr_addr, last_rd_addr, frame_valid);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
      check_idle_outputs("reset_state");
`ifdef FRAME_SCHED_STATS_EN
      total++;
      if (drop_cnt !== 16'd0 || frame_cnt !== 16'd0) begin
         bad++;
         $display("FAIL reset_stats: drop=%0d frames=%0d, want 0 0", drop_cnt, frame_cnt);
      end
`endif
   endtask

   task automatic test_write_frame();
      logic seen = 1'b0;
      line_ready = 1'b1;
      pulse_wr_sync();
      do_write(25'h10_0000, "wr_line0");
      do_write(25'h10_0400, "wr_line1");
      do_write(25'h10_0800, "wr_line2");
      do_write(25'h10_0C00, "wr_line3");
      total++;
      if (frame_valid !== 1'b1 || last_wr_addr !== 25'h10_0000) begin
         bad++;
         $display("FAIL frame_complete: fv=%b last_wr=%h, want 1 100000", frame_valid, last_wr_addr);
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         if (wr_start === 1'b1) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b0) begin
         bad++;
         $display("FAIL line_ready_after_complete: wr_start seen=%b, want 0", seen);
      end
      line_ready = 1'b0;
   endtask

   task automatic test_read_frame();
      rd_frame_sync = 1'b1;
      tick();
      rd_frame_sync = 1'b0;
      total++;
      if (last_rd_addr !== 25'h10_0000) begin
         bad++;
         $display("FAIL last_rd_addr: got %h want 100000", last_rd_addr);
      end
      do_read(25'h10_0000, "rd_line0");
      do_read(25'h10_0400, "rd_line1");
      do_read(25'h10_0800, "rd_line2");
      do_read(25'h10_0C00, "rd_line3");
      do_read(25'h10_0000, "rd_wrap");
   endtask

   // Read bank is 1: write banks must go 2, 0, then skip 1 to land on 2.
   task automatic test_bank_skip();
      line_ready = 1'b1;
      pulse_wr_sync();
      do_write(25'h20_0000, "skip_a0");
      do_write(25'h20_0400, "skip_a1");
      do_write(25'h20_0800, "skip_a2");
      do_write(25'h20_0C00, "skip_a3");
      pulse_wr_sync();
      do_write(25'h00_0000, "skip_b0");
      do_write(25'h00_0400, "skip_b1");
      do_write(25'h00_0800, "skip_b2");
      do_write(25'h00_0C00, "skip_b3");
      pulse_wr_sync();
      do_write(25'h20_0000, "skip_c0");
      do_write(25'h20_0400, "skip_c1");
      do_write(25'h20_0800, "skip_c2");
      do_write(25'h20_0C00, "skip_c3");
      total++;
      if (last_wr_addr !== 25'h20_0000) begin
         bad++;
         $display("FAIL skip_last_wr: got %h want 200000", last_wr_addr);
      end
   endtask

   task automatic test_sync_mid_busy();
      int n = 0;
      pulse_wr_sync();
      do_write(25'h00_0000, "mid_line0");
      do_write(25'h00_0400, "mid_line1");
      while (wr_start !== 1'b1 && n < 20) begin tick(); n++; end
      total++;
      if (wr_addr !== 25'h00_0800 || wr_start !== 1'b1) begin
         bad++;
         $display("FAIL mid_line2: start=%b addr=%h, want 1 000800", wr_start, wr_addr);
      end
      tick();
      pulse_wr_sync();
      total++;
      if (wr_addr !== 25'h00_0800) begin
         bad++;
         $display("FAIL mid_hold_addr: got %h want 000800", wr_addr);
      end
      wr_finish = 1'b1;
      tick();
      wr_finish = 1'b0;
      total++;
      if (frame_valid !== 1'b1 || last_wr_addr !== 25'h20_0000) begin
         bad++;
         $display("FAIL mid_unchanged: fv=%b last_wr=%h, want 1 200000", frame_valid, last_wr_addr);
      end
      tick();
      total++;
      if (wr_start !== 1'b1 || wr_addr !== 25'h20_0000) begin
         bad++;
         $display("FAIL mid_switch: start=%b addr=%h, want 1 200000", wr_start, wr_addr);
      end
      do_write(25'h20_0000, "mid_new0");
      line_ready = 1'b0;
   endtask

   task automatic test_drop();
      logic seen = 1'b0;
      int n = 0;
      test_reset();
      rd_line_req = 1'b1;
      tick();
      rd_line_req = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (rd_start === 1'b1) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b0) begin
         bad++;
         $display("FAIL drop_no_frame: rd_start seen=%b, want 0", seen);
      end
      line_ready = 1'b1;
      pulse_wr_sync();
      do_write(25'h10_0000, "drop_w0");
      do_write(25'h10_0400, "drop_w1");
      do_write(25'h10_0800, "drop_w2");
      do_write(25'h10_0C00, "drop_w3");
      line_ready = 1'b0;
      rd_frame_sync = 1'b1;
      tick();
      rd_frame_sync = 1'b0;
      rd_line_req = 1'b1;
      tick();
      rd_line_req = 1'b0;
      while (rd_start !== 1'b1 && n < 20) begin tick(); n++; end
      total++;
      if (rd_start !== 1'b1 || rd_addr !== 25'h10_0000) begin
         bad++;
         $display("FAIL drop_first_read: start=%b addr=%h, want 1 100000", rd_start, rd_addr);
      end
      tick();
      rd_line_req = 1'b1;
      tick();
      rd_line_req = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (rd_start === 1'b1) seen = 1'b1;
      end
      rd_finish = 1'b1;
      tick();
      rd_finish = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (rd_start === 1'b1) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b0) begin
         bad++;
         $display("FAIL drop_busy: rd_start seen=%b, want 0", seen);
      end
`ifdef FRAME_SCHED_STATS_EN
      total++;
      if (drop_cnt !== 16'd2 || frame_cnt !== 16'd1) begin
         bad++;
         $display("FAIL drop_stats: drop=%0d frames=%0d, want 2 1", drop_cnt, frame_cnt);
      end
`endif
   endtask

   task automatic test_reset_mid_busy();
      logic seen = 1'b0;
      int n = 0;
      line_ready = 1'b1;
      pulse_wr_sync();
      while (wr_start !== 1'b1 && n < 20) begin tick(); n++; end
      total++;
      if (wr_start !== 1'b1 || wr_addr !== 25'h20_0000) begin
         bad++;
         $display("FAIL rstbusy_start: start=%b addr=%h, want 1 200000", wr_start, wr_addr);
      end
      tick();
      rst = 1'b1;
      line_ready = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      wr_finish = 1'b1;
      tick();
      wr_finish = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (wr_start === 1'b1) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b0) begin
         bad++;
         $display("FAIL rstbusy_stray_finish: wr_start seen=%b, want 0", seen);
      end
      check_idle_outputs("rstbusy_outputs");
      line_ready = 1'b1;
      pulse_wr_sync();
      do_write(25'h10_0000, "rstbusy_bank_restart");
      line_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_write_frame();
      test_read_frame();
      test_bank_skip();
      test_sync_mid_busy();
      test_drop();
      test_reset_mid_busy();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
